// File: rtl/branch_sched.sv
// Age-ordered branch/jump issue scheduler: collapsing queue of NQ entries (slot 0 oldest),
// issues the oldest operand-complete op per cycle and drops ops squashed by commit_kill.
module branch_sched #(
  parameter int NQ         = 4,
  parameter int LNQ        = 2,
  parameter int NCOMMIT    = 32,
  parameter int LNCOMMIT   = 5,
  parameter int CNTRL_SIZE = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LNCOMMIT-1:0]   in_rd,
  input  logic                  in_makes_rd,
  input  logic [CNTRL_SIZE-1:0] in_control,
  input  logic                  in_dep1_valid,
  input  logic [LNCOMMIT-1:0]   in_dep1,
  input  logic                  in_dep2_valid,
  input  logic [LNCOMMIT-1:0]   in_dep2,
  input  logic [NCOMMIT-1:0]    commit_done,
  input  logic [NCOMMIT-1:0]    commit_kill,
  output logic                  br_enable,
  output logic [LNCOMMIT-1:0]   br_rd,
  output logic                  br_makes_rd,
  output logic [CNTRL_SIZE-1:0] br_control,
  output logic [LNQ:0]          count,
  output logic                  empty
);

  logic [NQ-1:0]                 valid_q, valid_d;
  logic [NQ-1:0][LNCOMMIT-1:0]   rd_q, rd_d;
  logic [NQ-1:0]                 mk_q, mk_d;
  logic [NQ-1:0][CNTRL_SIZE-1:0] ctl_q, ctl_d;
  logic [NQ-1:0]                 d1v_q, d1v_d;
  logic [NQ-1:0][LNCOMMIT-1:0]   d1_q, d1_d;
  logic [NQ-1:0]                 d2v_q, d2v_d;
  logic [NQ-1:0][LNCOMMIT-1:0]   d2_q, d2_d;
  logic [LNQ:0]                  count_q, count_d;

  logic                  br_enable_q;
  logic [LNCOMMIT-1:0]   br_rd_q;
  logic                  br_makes_rd_q;
  logic [CNTRL_SIZE-1:0] br_control_q;

  logic [NQ-1:0]  cand;
  logic [LNQ-1:0] sel;
  logic           issue;
  logic           accept;
  logic [LNQ:0]   k;

  assign in_ready    = (count_q != (LNQ+1)'(NQ));
  assign count       = count_q;
  assign empty       = (count_q == '0);
  assign br_enable   = br_enable_q;
  assign br_rd       = br_rd_q;
  assign br_makes_rd = br_makes_rd_q;
  assign br_control  = br_control_q;

  // Selection ignores kill so a killed oldest slot blocks issue rather than passing it to a younger one.
  always_comb begin
    cand = '0;
    sel  = '0;
    for (int i = 0; i < NQ; i++) begin
      cand[i] = valid_q[i] & (!d1v_q[i] | commit_done[d1_q[i]]) & (!d2v_q[i] | commit_done[d2_q[i]]);
    end
    for (int i = NQ-1; i >= 0; i--) begin
      if (cand[i]) sel = LNQ'(i);
    end
    issue = (|cand) & !commit_kill[rd_q[sel]];
  end

  always_comb begin
    valid_d = '0;
    rd_d    = rd_q;
    mk_d    = mk_q;
    ctl_d   = ctl_q;
    d1v_d   = d1v_q;
    d1_d    = d1_q;
    d2v_d   = d2v_q;
    d2_d    = d2_q;
    k       = '0;
    for (int i = 0; i < NQ; i++) begin
      if (valid_q[i] && !commit_kill[rd_q[i]] && !(issue && sel == LNQ'(i))) begin
        valid_d[k[LNQ-1:0]] = 1'b1;
        rd_d[k[LNQ-1:0]]    = rd_q[i];
        mk_d[k[LNQ-1:0]]    = mk_q[i];
        ctl_d[k[LNQ-1:0]]   = ctl_q[i];
        d1v_d[k[LNQ-1:0]]   = d1v_q[i];
        d1_d[k[LNQ-1:0]]    = d1_q[i];
        d2v_d[k[LNQ-1:0]]   = d2v_q[i];
        d2_d[k[LNQ-1:0]]    = d2_q[i];
        k                   = k + (LNQ+1)'(1);
      end
    end
    // A dependency already satisfied at accept is stored as resolved.
    accept = in_valid & in_ready & !commit_kill[in_rd];
    if (accept) begin
      valid_d[k[LNQ-1:0]] = 1'b1;
      rd_d[k[LNQ-1:0]]    = in_rd;
      mk_d[k[LNQ-1:0]]    = in_makes_rd;
      ctl_d[k[LNQ-1:0]]   = in_control;
      d1v_d[k[LNQ-1:0]]   = in_dep1_valid & !commit_done[in_dep1];
      d1_d[k[LNQ-1:0]]    = in_dep1;
      d2v_d[k[LNQ-1:0]]   = in_dep2_valid & !commit_done[in_dep2];
      d2_d[k[LNQ-1:0]]    = in_dep2;
    end
    count_d = k + (LNQ+1)'(accept);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q       <= '0;
      rd_q          <= '0;
      mk_q          <= '0;
      ctl_q         <= '0;
      d1v_q         <= '0;
      d1_q          <= '0;
      d2v_q         <= '0;
      d2_q          <= '0;
      count_q       <= '0;
      br_enable_q   <= 1'b0;
      br_rd_q       <= '0;
      br_makes_rd_q <= 1'b0;
      br_control_q  <= '0;
    end else begin
      valid_q     <= valid_d;
      rd_q        <= rd_d;
      mk_q        <= mk_d;
      ctl_q       <= ctl_d;
      d1v_q       <= d1v_d;
      d1_q        <= d1_d;
      d2v_q       <= d2v_d;
      d2_q        <= d2_d;
      count_q     <= count_d;
      br_enable_q <= issue;
      if (issue) begin
        br_rd_q       <= rd_q[sel];
        br_makes_rd_q <= mk_q[sel];
        br_control_q  <= ctl_q[sel];
      end
    end
  end

endmodule

// File: tb/tb_branch_sched.sv
// Scoreboard bench for branch_sched: directed ops push expected issues, a negedge monitor
// pops and compares every br_enable strobe.
module tb_branch_sched;

  typedef struct packed {
    logic [4:0] rd;
    logic       mk;
    logic [6:0] ctl;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_makes_rd;
  logic [6:0]  in_control;
  logic        in_dep1_valid;
  logic [4:0]  in_dep1;
  logic        in_dep2_valid;
  logic [4:0]  in_dep2;
  logic [31:0] commit_done;
  logic [31:0] commit_kill;
  logic        br_enable;
  logic [4:0]  br_rd;
  logic        br_makes_rd;
  logic [6:0]  br_control;
  logic [2:0]  count;
  logic        empty;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  branch_sched dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_makes_rd(in_makes_rd),
    .in_control(in_control), .in_dep1_valid(in_dep1_valid), .in_dep1(in_dep1),
    .in_dep2_valid(in_dep2_valid), .in_dep2(in_dep2),
    .commit_done(commit_done), .commit_kill(commit_kill),
    .br_enable(br_enable), .br_rd(br_rd), .br_makes_rd(br_makes_rd), .br_control(br_control),
    .count(count), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Monitor pops the oldest expectation on every issue strobe.
  always @(negedge clk) begin
    if (reset && br_enable) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_issue: got rd=%0d expected no issue", br_rd);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("issue_rd", int'(br_rd), int'(e.rd));
        checkOutput("issue_makes_rd", int'(br_makes_rd), int'(e.mk));
        checkOutput("issue_control", int'(br_control), int'(e.ctl));
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One cycle offering an op; in_valid drops after the accepting edge.
  task automatic applyStimulus(input logic [4:0] rd, input logic mk, input logic [6:0] ctl,
                               input logic d1v, input logic [4:0] d1,
                               input logic d2v, input logic [4:0] d2);
    in_valid      = 1'b1;
    in_rd         = rd;
    in_makes_rd   = mk;
    in_control    = ctl;
    in_dep1_valid = d1v;
    in_dep1       = d1;
    in_dep2_valid = d2v;
    in_dep2       = d2;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic expectIssue(input logic [4:0] rd, input logic mk, input logic [6:0] ctl);
    exp_t e;
    e.rd  = rd;
    e.mk  = mk;
    e.ctl = ctl;
    sb.push_back(e);
  endtask

  initial begin
    reset = 1'b0;
    in_valid = 1'b0; in_rd = '0; in_makes_rd = 1'b0; in_control = '0;
    in_dep1_valid = 1'b0; in_dep1 = '0; in_dep2_valid = 1'b0; in_dep2 = '0;
    commit_done = '0; commit_kill = '0;
    idle(2);
    checkOutput("rst_count", int'(count), 0);
    checkOutput("rst_empty", int'(empty), 1);
    checkOutput("rst_in_ready", int'(in_ready), 1);
    checkOutput("rst_br_enable", int'(br_enable), 0);
    checkOutput("rst_br_rd", int'(br_rd), 0);
    checkOutput("rst_br_makes_rd", int'(br_makes_rd), 0);
    checkOutput("rst_br_control", int'(br_control), 0);
    reset = 1'b1;
    idle(1);

    // Single op, minimum latency
    expectIssue(5'd3, 1'b1, 7'h21);
    applyStimulus(5'd3, 1'b1, 7'h21, 1'b0, 5'd0, 1'b0, 5'd0);
    checkOutput("single_count_after_accept", int'(count), 1);
    checkOutput("single_no_early_issue", int'(br_enable), 0);
    idle(1);
    checkOutput("single_br_enable", int'(br_enable), 1);
    checkOutput("single_count_after_issue", int'(count), 0);
    idle(1);
    checkOutput("single_br_enable_drop", int'(br_enable), 0);
    checkOutput("single_br_rd_hold", int'(br_rd), 3);

    // Fill to capacity behind dep 10
    for (int i = 1; i <= 4; i++)
      applyStimulus(5'(i), 1'b0, 7'(i + 16), 1'b1, 5'd10, 1'b0, 5'd0);
    checkOutput("fill_count", int'(count), 4);
    checkOutput("fill_in_ready", int'(in_ready), 0);
    applyStimulus(5'd9, 1'b0, 7'h7f, 1'b0, 5'd0, 1'b0, 5'd0);
    checkOutput("fill_reject_count", int'(count), 4);
    commit_done[10] = 1'b1;
    for (int i = 1; i <= 4; i++) expectIssue(5'(i), 1'b0, 7'(i + 16));
    idle(4);
    checkOutput("fill_drain_count", int'(count), 0);
    checkOutput("fill_drain_empty", int'(empty), 1);
    idle(1);
    commit_done = '0;

    // Age order: younger ready op passes older blocked one (dep on source 2)
    applyStimulus(5'd5, 1'b1, 7'h05, 1'b0, 5'd0, 1'b1, 5'd8);
    expectIssue(5'd6, 1'b0, 7'h06);
    applyStimulus(5'd6, 1'b0, 7'h06, 1'b0, 5'd0, 1'b0, 5'd0);
    idle(2);
    checkOutput("age_count_blocked", int'(count), 1);
    commit_done[8] = 1'b1;
    expectIssue(5'd5, 1'b1, 7'h05);
    idle(2);
    checkOutput("age_count_done", int'(count), 0);
    commit_done = '0;

    // Kill a middle entry
    for (int i = 1; i <= 3; i++)
      applyStimulus(5'(i), 1'b0, 7'(i + 32), 1'b1, 5'd12, 1'b0, 5'd0);
    checkOutput("kill_count_before", int'(count), 3);
    commit_kill[2] = 1'b1;
    idle(1);
    commit_kill = '0;
    checkOutput("kill_count_after", int'(count), 2);
    commit_done[12] = 1'b1;
    expectIssue(5'd1, 1'b0, 7'd33);
    expectIssue(5'd3, 1'b0, 7'd35);
    idle(3);
    checkOutput("kill_drain_count", int'(count), 0);
    commit_done = '0;

    // Kill at accept
    commit_kill[7] = 1'b1;
    applyStimulus(5'd7, 1'b0, 7'h07, 1'b0, 5'd0, 1'b0, 5'd0);
    commit_kill = '0;
    checkOutput("kill_accept_count", int'(count), 0);
    checkOutput("kill_accept_empty", int'(empty), 1);
    idle(2);

    // Dependency already done at accept is captured as resolved
    commit_done[20] = 1'b1;
    expectIssue(5'd9, 1'b1, 7'h49);
    applyStimulus(5'd9, 1'b1, 7'h49, 1'b1, 5'd20, 1'b0, 5'd0);
    commit_done = '0;
    idle(2);
    checkOutput("capture_count", int'(count), 0);

    // Asynchronous reset mid-operation
    for (int i = 1; i <= 3; i++)
      applyStimulus(5'(i), 1'b0, 7'(i), 1'b1, 5'd14, 1'b0, 5'd0);
    checkOutput("rst_mid_count_before", int'(count), 3);
    commit_done[14] = 1'b1;
    idle(1);
    checkOutput("rst_mid_br_enable_before", int'(br_enable), 1);
    checkOutput("rst_mid_br_rd_before", int'(br_rd), 1);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("rst_mid_count", int'(count), 0);
    checkOutput("rst_mid_br_enable", int'(br_enable), 0);
    checkOutput("rst_mid_empty", int'(empty), 1);
    checkOutput("rst_mid_in_ready", int'(in_ready), 1);
    checkOutput("rst_mid_br_rd", int'(br_rd), 0);
    idle(2);
    reset = 1'b1;
    idle(4);
    checkOutput("rst_release_count", int'(count), 0);
    commit_done = '0;

    idle(1);
    checkOutput("sb_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
